// File: rtl/block_serializer.sv
// Block serializer: pops 8*NUM_BYTES-bit blocks from a FIFO and streams
// them byte by byte over a valid/ready link, counting completed blocks.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   fifo_dout/_empty      block data and empty flag from the upstream FIFO
//   fifo_read_en          one-cycle pop request to the FIFO
//   tx_data/_valid/_ready byte stream towards the transmitter
//   busy                  FSM is not in IDLE
//   block_done            one-cycle pulse on acceptance of a block's last byte
//   block_count           blocks fully sent since reset (wraps at 16 bits)
module block_serializer #(
  parameter int NUM_BYTES  = 16,
  parameter int RD_LATENCY = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_BYTES-1:0] fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_read_en,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   block_done,
  output logic [15:0]            block_count
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);
  localparam logic [1:0]    LAT_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [IW-1:0]  idx_q,   idx_d;
  logic [1:0]     lat_q,   lat_d;
  logic           rd_q,    rd_d;
  logic [7:0]     data_q,  data_d;
  logic           valid_q, valid_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic [15:0]    cnt_q,   cnt_d;

  logic accept;
  logic last;

  // The byte currently on offer always sits at the head of the
  // shift register; the head end depends on the transmit order.
  function automatic logic [7:0] head(input logic [W-1:0] v);
    if (MSB_FIRST) return v[W-1 -: 8];
    return v[7:0];
  endfunction

  function automatic logic [W-1:0] drop(input logic [W-1:0] v);
    if (MSB_FIRST) return v << 8;
    return v >> 8;
  endfunction

  assign accept = valid_q & tx_ready;
  assign last   = (idx_q == LAST_IDX);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!fifo_empty)          state_d = REQ;
      REQ:                            state_d = WAIT;
      WAIT: if (lat_q == LAT_LAST)    state_d = SEND;
      SEND: if (accept && last)       state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values. Outputs are computed
  // from state_d so that each one is valid in the cycle its state holds.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rd_d    = (state_d == REQ);
    busy_d  = (state_d != IDLE);
    unique case (state_q)
      IDLE: ;
      REQ:  lat_d = '0;
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          shreg_d = fifo_dout;
          data_d  = head(fifo_dout);
          valid_d = 1'b1;
          idx_d   = '0;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND: begin
        if (accept) begin
          if (last) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            shreg_d = drop(shreg_q);
            data_d  = head(drop(shreg_q));
            idx_d   = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign fifo_read_en = rd_q;
  assign tx_data      = data_q;
  assign tx_valid     = valid_q;
  assign busy         = busy_q;
  assign block_done   = done_q;
  assign block_count  = cnt_q;

endmodule
